cuckoo_match_collector: RTL and testbench

Downstream stage of the three-stage cuckoo lookup (hash → index RAM → signature RAM → compare). It re-aligns the per-byte `compare_out`/`suffix` results of the case and nocase lookup paths with the payload byte offset that produced them, and merges both paths into one record per hit byte. Records go into a small FIFO and are drained by the rule-resolution logic over a valid/ready handshake. End-of-packet records carry the packet length, and overflow accounting is kept per packet.

---
 rtl/cuckoo_pkg.sv | 23 ++
 rtl/cuckoo_match_collector_if.sv | 11 +
 rtl/sync_fifo_fwft.sv | 56 +++++
 rtl/cuckoo_match_collector.sv | 171 +++++++++++++++++
 tb/tb_cuckoo_match_collector.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cuckoo_pkg.sv
// Shared constants for the cuckoo lookup match collector: record layout,
// field widths and default pipeline/FIFO sizing.
package cuckoo_pkg;

  localparam int LAT_DEF   = 4;
  localparam int DEPTH_DEF = 16;
  localparam int OFS_W_DEF = 16;
  localparam int HIT_W     = 2;
  localparam int SFX_W     = 2;
  localparam int DROP_W    = 16;
  localparam int REC_W_DEF = OFS_W_DEF + 9;

  typedef enum logic {
    REC_MATCH = 1'b0,
    REC_EOP   = 1'b1
  } rec_kind_e;

  // Record = {kind, offset, hit_c, sfx_c, hit_n, sfx_n}
  function automatic int rec_w(input int ofs_w);
    return ofs_w + 1 + 2 * (HIT_W + SFX_W);
  endfunction

endpackage

// File: rtl/cuckoo_match_collector_if.sv
// Record stream from the match collector to the rule-resolution logic.
interface cuckoo_match_collector_if #(
  parameter int W = cuckoo_pkg::REC_W_DEF
);
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy output; head word is presented
// combinationally and reads as zero while empty.
module sync_fifo_fwft #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          wr_ok, rd_ok;

  assign rd_valid = (count_q != '0);
  assign rd_ok    = rd_en && rd_valid;
  // A read frees the slot at full, so a simultaneous write still lands.
  assign wr_ok    = wr_en && ((count_q != (AW+1)'(DEPTH)) || rd_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/cuckoo_match_collector.sv
// Re-aligns cuckoo lookup hits with their payload byte offsets, merges case
// and nocase paths into records and queues them with per-packet drop accounting.
module cuckoo_match_collector
  import cuckoo_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int OFS_W = OFS_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      sop,
  input  logic                      eop,
  input  logic [HIT_W-1:0]          compare_out,
  input  logic [SFX_W-1:0]          suffix,
  input  logic [HIT_W-1:0]          compare_out_nocase,
  input  logic [SFX_W-1:0]          suffix_nocase,
  cuckoo_match_collector_if.master  m,
  output logic                      overflow,
  output logic [DROP_W-1:0]         drop_cnt
);
  localparam int REC_W = rec_w(OFS_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [OFS_W-1:0] ofs_q, ofs_d, tag;
  logic [LAT-1:0]   dl_vld_q, dl_eop_q, dl_sop_q;
  logic [OFS_W-1:0] dl_ofs_q [LAT];

  logic             e_vld, e_eop, e_sop;
  logic [OFS_W-1:0] e_ofs, e_len;
  logic [SFX_W-1:0] sfx_c, sfx_n;
  logic             is_match, is_eop;
  logic [REC_W-1:0] match_rec, eop_rec;

  logic             pend_vld_q, pend_vld_d;
  logic [REC_W-1:0] pend_rec_q, pend_rec_d;
  logic             push_req, push_eop, lost_match;
  logic [REC_W-1:0] push_rec;

  logic             admit, fifo_wr, fifo_valid;
  logic [CNT_W-1:0] fifo_count;
  logic [REC_W-1:0] fifo_rd_data;
  logic [1:0]       drop_n;
  logic             pkt_clr;
  logic [DROP_W-1:0] drop_q, drop_d, drop_base;
  logic [DROP_W:0]   drop_sum;
  logic             ovf_q, ovf_d;

  always_comb begin
    ofs_d = ofs_q;
    tag   = ofs_q;
    if (enable) begin
      if (sop) begin
        tag   = '0;
        ofs_d = OFS_W'(1);
      end else if (ofs_q != '1) begin
        ofs_d = ofs_q + 1'b1;
      end
    end
  end

  // Free-running delay line: the lookup RAMs do not stall, so neither may this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ofs_q    <= '0;
      dl_vld_q <= '0;
      dl_eop_q <= '0;
      dl_sop_q <= '0;
      for (int i = 0; i < LAT; i++) dl_ofs_q[i] <= '0;
    end else begin
      ofs_q       <= ofs_d;
      dl_vld_q[0] <= enable;
      dl_eop_q[0] <= enable & eop;
      dl_sop_q[0] <= enable & sop;
      dl_ofs_q[0] <= tag;
      for (int i = 1; i < LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_eop_q[i] <= dl_eop_q[i-1];
        dl_sop_q[i] <= dl_sop_q[i-1];
        dl_ofs_q[i] <= dl_ofs_q[i-1];
      end
    end
  end

  assign e_vld = dl_vld_q[LAT-1];
  assign e_eop = dl_eop_q[LAT-1];
  assign e_sop = dl_sop_q[LAT-1];
  assign e_ofs = dl_ofs_q[LAT-1];
  assign e_len = (&e_ofs) ? e_ofs : e_ofs + 1'b1;

  assign sfx_c     = (|compare_out)        ? suffix        : '0;
  assign sfx_n     = (|compare_out_nocase) ? suffix_nocase : '0;
  assign is_match  = e_vld && (|(compare_out | compare_out_nocase));
  assign is_eop    = e_vld && e_eop;
  assign match_rec = {REC_MATCH, e_ofs, compare_out, sfx_c, compare_out_nocase, sfx_n};
  assign eop_rec   = {REC_EOP, e_len, {(2*(HIT_W+SFX_W)){1'b0}}};

  // A held EOP always goes first; a match arriving behind it is lost.
  always_comb begin
    push_req   = 1'b0;
    push_eop   = 1'b0;
    push_rec   = '0;
    lost_match = 1'b0;
    pend_vld_d = 1'b0;
    pend_rec_d = pend_rec_q;
    if (pend_vld_q) begin
      push_req   = 1'b1;
      push_eop   = 1'b1;
      push_rec   = pend_rec_q;
      lost_match = is_match;
      pend_vld_d = is_eop;
      pend_rec_d = eop_rec;
    end else if (is_match) begin
      push_req   = 1'b1;
      push_rec   = match_rec;
      pend_vld_d = is_eop;
      pend_rec_d = eop_rec;
    end else if (is_eop) begin
      push_req   = 1'b1;
      push_eop   = 1'b1;
      push_rec   = eop_rec;
    end
  end

  // Last FIFO slot is reserved so a packet's length record survives backpressure.
  assign admit   = push_eop ? (fifo_count < CNT_W'(DEPTH))
                            : (fifo_count < CNT_W'(DEPTH - 1));
  assign fifo_wr = push_req && admit;
  assign drop_n  = 2'(push_req && !admit) + 2'(lost_match);

  assign pkt_clr   = e_vld && e_sop;
  assign drop_base = pkt_clr ? '0 : drop_q;
  assign drop_sum  = {1'b0, drop_base} + {{(DROP_W-1){1'b0}}, drop_n};
  assign drop_d    = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  assign ovf_d     = (!pkt_clr && ovf_q) || (drop_n != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_rec_q <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_rec_q <= pend_rec_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo_fwft #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (push_rec),
    .rd_en    (fifo_valid & m.m_ready),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  assign m.m_valid = fifo_valid;
  assign m.m_data  = fifo_rd_data;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cuckoo_match_collector.sv
// Bench for cuckoo_match_collector: a delayed lookup model feeds hits, and a
// scoreboard queue of expected records is checked as the consumer drains them.
module tb_cuckoo_match_collector;
  import cuckoo_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 16;
  localparam int OFS_W = 16;
  localparam int REC_W = OFS_W + 9;
  localparam int NV    = 16;

  typedef struct {
    logic             s, e;
    logic [1:0]       hc, sc, hn, sn;
    logic             mv;
    logic [REC_W-1:0] m;
    logic             ev;
    logic [REC_W-1:0] er;
    int               idle;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [1:0] hc_in = '0, sc_in = '0, hn_in = '0, sn_in = '0;
  logic [7:0] lk_pipe [LAT];
  logic [1:0] compare_out, suffix, compare_out_nocase, suffix_nocase;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic [REC_W-1:0] exp_q [$];
  logic [REC_W-1:0] exp_r;
  vec_t vecs [NV];
  vec_t v;
  int total = 0;
  int bad   = 0;
  int n_rec = 0;
  int k;

  always #5 clk = ~clk;

  cuckoo_match_collector_if #(.W(REC_W)) mif ();

  cuckoo_match_collector #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .OFS_W (OFS_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .sop                (sop),
    .eop                (eop),
    .compare_out        (compare_out),
    .suffix             (suffix),
    .compare_out_nocase (compare_out_nocase),
    .suffix_nocase      (suffix_nocase),
    .m                  (mif),
    .overflow           (overflow),
    .drop_cnt           (drop_cnt)
  );

  // Lookup model: results appear LAT cycles after the byte; idle slots carry hit noise.
  always @(posedge clk) begin
    lk_pipe[0] <= enable ? {hc_in, sc_in, hn_in, sn_in} : 8'hFF;
    for (int i = 1; i < LAT; i++) lk_pipe[i] <= lk_pipe[i-1];
  end
  assign {compare_out, suffix, compare_out_nocase, suffix_nocase} = lk_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mrec(int o, int hc, int sc, int hn, int sn);
    return {1'b0, OFS_W'(o), 2'(hc), 2'(sc), 2'(hn), 2'(sn)};
  endfunction

  function automatic logic [REC_W-1:0] erec(int len);
    return {1'b1, OFS_W'(len), 8'h00};
  endfunction

  function automatic vec_t mkv(int s, int e, int hc, int sc, int hn, int sn,
                               int mv, logic [REC_W-1:0] m, int ev,
                               logic [REC_W-1:0] er, int idle);
    vec_t r;
    r.s = 1'(s);   r.e = 1'(e);
    r.hc = 2'(hc); r.sc = 2'(sc); r.hn = 2'(hn); r.sn = 2'(sn);
    r.mv = 1'(mv); r.m = m; r.ev = 1'(ev); r.er = er; r.idle = idle;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input vec_t x);
    enable = 1'b1; sop = x.s; eop = x.e;
    hc_in = x.hc; sc_in = x.sc; hn_in = x.hn; sn_in = x.sn;
    if (x.mv) exp_q.push_back(x.m);
    if (x.ev) exp_q.push_back(x.er);
    @(posedge clk);
    #1;
    enable = 1'b0; sop = 1'b0; eop = 1'b0;
    hc_in = '0; sc_in = '0; hn_in = '0; sn_in = '0;
    idle(x.idle);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mif.m_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Consumer side: every accepted record is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst && mif.m_valid && mif.m_ready) begin
      n_rec++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rec: got %0h expected none", mif.m_data);
      end else begin
        exp_r = exp_q.pop_front();
        $display("rec %0d: got %h want %h", n_rec, mif.m_data, exp_r);
        chk("rec_data", mif.m_data, exp_r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mif.m_ready = 1'b0;

    vecs[0]  = mkv(1,0, 0,3,0,3, 0,'0,            0,'0,       0);
    vecs[1]  = mkv(0,0, 0,1,0,2, 0,'0,            0,'0,       0);
    vecs[2]  = mkv(0,0, 0,2,0,1, 0,'0,            0,'0,       0);
    vecs[3]  = mkv(0,0, 0,3,0,3, 0,'0,            0,'0,       0);
    vecs[4]  = mkv(0,0, 0,0,0,0, 0,'0,            0,'0,       0);
    vecs[5]  = mkv(0,0, 1,2,0,1, 1,mrec(5,1,2,0,0), 0,'0,     0);
    vecs[6]  = mkv(0,0, 0,3,1,3, 1,mrec(6,0,0,1,3), 0,'0,     0);
    vecs[7]  = mkv(0,0, 0,1,0,1, 0,'0,            0,'0,       0);
    vecs[8]  = mkv(0,0, 0,0,0,2, 0,'0,            0,'0,       0);
    vecs[9]  = mkv(0,1, 0,0,0,0, 0,'0,            1,erec(10), 2);
    vecs[10] = mkv(1,0, 0,0,0,0, 0,'0,            0,'0,       0);
    vecs[11] = mkv(0,0, 0,0,0,0, 0,'0,            0,'0,       0);
    vecs[12] = mkv(0,0, 0,0,0,0, 0,'0,            0,'0,       0);
    vecs[13] = mkv(0,1, 2,1,3,2, 1,mrec(3,2,1,3,2), 1,erec(4), 2);
    vecs[14] = mkv(1,1, 0,0,0,0, 0,'0,            1,erec(1),  2);
    vecs[15] = mkv(1,1, 1,1,0,2, 1,mrec(0,1,1,0,0), 1,erec(1), 2);

    // Reset state
    idle(2);
    chk("rst_m_valid", mif.m_valid, 0);
    chk("rst_m_data", mif.m_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b1;
    idle(LAT + 2);
    chk("idle_noise_no_valid", mif.m_valid, 0);

    // Table-driven packets
    mif.m_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(vecs[i]);
    wait_drain();

    // First-record latency
    send(mkv(1,0, 1,1,0,0, 1,mrec(0,1,1,0,0), 0,'0, 0));
    k = 0;
    while (!mif.m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_latency", k, LAT + 1);
    wait_drain();

    // Backpressure overflow: 20 hits, then EOP into the reserved slot
    mif.m_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      send(mkv((i == 0) ? 1 : 0, 0, 1,1,0,0, (i < 15) ? 1 : 0, mrec(i,1,1,0,0), 0,'0, 0));
    send(mkv(0,1, 0,0,0,0, 0,'0, 1,erec(21), 0));
    idle(LAT + 3);
    chk("ovf_drop_cnt", drop_cnt, 5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_m_valid", mif.m_valid, 1);
    chk("ovf_queued", exp_q.size(), 16);
    for (int i = 0; i < 3; i++) begin
      chk("hold_m_data", mif.m_data, exp_q[0]);
      idle(1);
    end
    mif.m_ready = 1'b1;
    wait_drain();
    chk("ovf_drop_kept", drop_cnt, 5);
    send(mkv(1,0, 0,0,0,0, 0,'0, 0,'0, 0));
    idle(LAT + 1);
    chk("clr_drop_cnt", drop_cnt, 0);
    chk("clr_overflow", overflow, 0);

    // Sparse enable: one byte every third cycle
    for (int i = 0; i < 6; i++) begin
      if (i == 2)      v = mkv(0,0, 1,3,0,1, 1,mrec(2,1,3,0,0), 0,'0, 2);
      else if (i == 4) v = mkv(0,0, 1,3,2,1, 1,mrec(4,1,3,2,1), 0,'0, 2);
      else             v = mkv((i == 0) ? 1 : 0, (i == 5) ? 1 : 0, 0,2,0,2, 0,'0,
                               (i == 5) ? 1 : 0, erec(6), 2);
      send(v);
    end
    wait_drain();

    // Asynchronous reset with records queued
    mif.m_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(mkv((i == 0) ? 1 : 0, 0, 1,2,0,0, 1,mrec(i,1,2,0,0), 0,'0, 0));
    idle(LAT + 2);
    chk("pre_rst_m_valid", mif.m_valid, 1);
    chk("pre_rst_queued", exp_q.size(), 3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_m_valid", mif.m_valid, 0);
    chk("async_rst_m_data", mif.m_data, 0);
    exp_q.delete();
    idle(2);
    rst = 1'b1;
    idle(1);
    mif.m_ready = 1'b1;
    send(mkv(1,0, 2,3,0,0, 1,mrec(0,2,3,0,0), 0,'0, 0));
    send(mkv(0,0, 0,1,2,1, 1,mrec(1,0,0,2,1), 0,'0, 0));
    send(mkv(0,1, 0,0,0,0, 0,'0, 1,erec(3), 2));
    wait_drain();

    idle(10);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_m_valid", mif.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
